// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - MIPS-style ALU: arith, logic, shift and compare with a registered result
module mips_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALUFun,
  input  logic        Sign,
  output logic [31:0] result
);

  localparam logic [1:0] CLASS_ARITH = 2'b00;
  localparam logic [1:0] CLASS_LOGIC = 2'b01;
  localparam logic [1:0] CLASS_SHIFT = 2'b10;
  localparam logic [1:0] CLASS_CMP   = 2'b11;

  localparam logic [3:0] LOGIC_AND  = 4'b1000;
  localparam logic [3:0] LOGIC_OR   = 4'b1110;
  localparam logic [3:0] LOGIC_XOR  = 4'b0110;
  localparam logic [3:0] LOGIC_NOR  = 4'b0001;
  localparam logic [3:0] LOGIC_PASS = 4'b1010;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  localparam logic [2:0] CMP_NEQ = 3'b000;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_GEZ = 3'b100;
  localparam logic [2:0] CMP_LEZ = 3'b110;
  localparam logic [2:0] CMP_GTZ = 3'b111;

  logic [31:0] arith_res;
  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [31:0] cmp_res;
  logic [31:0] next_result;
  logic [31:0] b_operand;
  logic [4:0]  shamt;
  logic        cmp_flag;
  logic        a_zero;
  logic        a_neg;
  logic        lt;

  // Subtract as A + ~B + 1 so one adder serves both operations.
  always_comb begin
    b_operand = ALUFun[0] ? ~B : B;
    arith_res = A + b_operand + {31'b0, ALUFun[0]};
  end

  always_comb begin
    logic_res = 32'h0;
    case (ALUFun[3:0])
      LOGIC_AND:  logic_res = A & B;
      LOGIC_OR:   logic_res = A | B;
      LOGIC_XOR:  logic_res = A ^ B;
      LOGIC_NOR:  logic_res = ~(A | B);
      LOGIC_PASS: logic_res = A;
      default:    logic_res = 32'h0;
    endcase
  end

  always_comb begin
    shamt     = A[4:0];
    shift_res = 32'h0;
    case (ALUFun[1:0])
      SHIFT_SLL: shift_res = B << shamt;
      SHIFT_SRL: shift_res = B >> shamt;
      SHIFT_SRA: shift_res = 32'($signed(B) >>> shamt);
      default:   shift_res = 32'h0;
    endcase
  end

  // With Sign = 0 nothing is negative, which collapses LEZ/GEZ/GTZ to zero tests.
  always_comb begin
    a_zero   = (A == 32'h0);
    a_neg    = Sign & A[31];
    lt       = Sign ? ($signed(A) < $signed(B)) : (A < B);
    cmp_flag = 1'b0;
    case (ALUFun[3:1])
      CMP_EQ:  cmp_flag = (A == B);
      CMP_NEQ: cmp_flag = (A != B);
      CMP_LT:  cmp_flag = lt;
      CMP_LEZ: cmp_flag = a_neg | a_zero;
      CMP_GEZ: cmp_flag = ~a_neg;
      CMP_GTZ: cmp_flag = ~a_neg & ~a_zero;
      default: cmp_flag = 1'b0;
    endcase
    cmp_res = {31'b0, cmp_flag};
  end

  always_comb begin
    next_result = 32'h0;
    case (ALUFun[5:4])
      CLASS_ARITH: next_result = arith_res;
      CLASS_LOGIC: next_result = logic_res;
      CLASS_SHIFT: next_result = shift_res;
      CLASS_CMP:   next_result = cmp_res;
      default:     next_result = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      result <= 32'h0;
    end else begin
      result <= next_result;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - directed and randomized checks of mips_alu against an arithmetic reference model
module tb_mips_alu;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  ALUFun;
  logic        Sign;
  logic [31:0] result;

  int vectors;
  int miscompares;

  localparam longint TWO32 = 64'd4294967296;

  mips_alu dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .ALUFun (ALUFun),
    .Sign   (Sign),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one set of inputs, let one edge pass, then sample away from the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                      input logic s, input logic r);
    A      = a;
    B      = b;
    ALUFun = f;
    Sign   = s;
    reset  = r;
    @(posedge clk);
    #1;
  endtask

  function automatic longint as_signed(input logic [31:0] v);
    longint u;
    u = longint'(v);
    return v[31] ? u - TWO32 : u;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f, input logic s);
    longint ua, ub, sa, sb, p, q, x, y;
    int     n;
    bit     flag;
    ua = longint'(a);
    ub = longint'(b);
    sa = as_signed(a);
    sb = as_signed(b);
    case (f[5:4])
      2'd0: return f[0] ? 32'((ua - ub + TWO32) % TWO32) : 32'((ua + ub) % TWO32);
      2'd1: begin
        case (f[3:0])
          4'b1000: return a & b;
          4'b1110: return a | b;
          4'b0110: return a ^ b;
          4'b0001: return ~(a | b);
          4'b1010: return a;
          default: return 32'h0;
        endcase
      end
      2'd2: begin
        n = int'(a[4:0]);
        p = longint'(1) << n;
        case (f[1:0])
          2'b00: return 32'((ub * p) % TWO32);
          2'b01: return 32'(ub / p);
          2'b11: begin
            q = (sb >= 0) ? sb / p : -((-sb + p - 1) / p);
            return 32'((q + TWO32) % TWO32);
          end
          default: return 32'h0;
        endcase
      end
      default: begin
        x = s ? sa : ua;
        y = s ? sb : ub;
        case (f[3:1])
          3'b001:  flag = (ua == ub);
          3'b000:  flag = (ua != ub);
          3'b010:  flag = (x < y);
          3'b110:  flag = (x <= 0);
          3'b100:  flag = (x >= 0);
          3'b111:  flag = (x > 0);
          default: flag = 1'b0;
        endcase
        return {31'b0, flag};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] OPA = 32'h0000_E129;
  localparam logic [31:0] OPB = 32'hFFFF_1EDF;

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    logic        rs, rr;
    logic [31:0] exp;

    vectors     = 0;
    miscompares = 0;

    step($urandom, $urandom, 6'b000000, 1'b0, 1'b0);
    step(32'hFFFF_FFFF, 32'h1, 6'b000000, 1'b1, 1'b0);
    check("reset_state", result, 32'h0);

    step(OPA, OPB, 6'b000000, 1'b0, 1'b1); check("add",   result, 32'h0000_0008);
    step(OPA, OPB, 6'b000001, 1'b0, 1'b1); check("sub",   result, 32'h0001_C24A);
    step(OPA, OPB, 6'b011000, 1'b0, 1'b1); check("and",   result, 32'h0000_0009);
    step(OPA, OPB, 6'b011110, 1'b0, 1'b1); check("or",    result, 32'hFFFF_FFFF);
    step(OPA, OPB, 6'b010110, 1'b0, 1'b1); check("xor",   result, 32'hFFFF_FFF6);
    step(OPA, OPB, 6'b010001, 1'b0, 1'b1); check("nor",   result, 32'h0000_0000);
    step(OPA, OPB, 6'b011010, 1'b1, 1'b1); check("pass_a", result, 32'h0000_E129);

    step(OPA, OPB, 6'b100000, 1'b0, 1'b1); check("sll", result, 32'hFE3D_BE00);
    step(OPA, OPB, 6'b100001, 1'b0, 1'b1); check("srl", result, 32'h007F_FF8F);
    step(OPA, OPB, 6'b100011, 1'b1, 1'b1); check("sra", result, 32'hFFFF_FF8F);
    step(32'h0, OPB, 6'b100011, 1'b0, 1'b1); check("sra_amt0", result, OPB);

    step(OPA, OPB, 6'b110010, 1'b1, 1'b1); check("eq",  result, 32'h0);
    step(OPA, OPB, 6'b110000, 1'b0, 1'b1); check("neq", result, 32'h1);
    step(OPA, OPB, 6'b110100, 1'b1, 1'b1); check("lt_signed",   result, 32'h0);
    step(OPA, OPB, 6'b110100, 1'b0, 1'b1); check("lt_unsigned", result, 32'h1);
    for (int s = 0; s < 2; s++) begin
      step(OPA, OPB, 6'b111110, 1'(s), 1'b1); check($sformatf("gtz_s%0d", s), result, 32'h1);
      step(OPA, OPB, 6'b111100, 1'(s), 1'b1); check($sformatf("lez_s%0d", s), result, 32'h0);
      step(OPA, OPB, 6'b111000, 1'(s), 1'b1); check($sformatf("gez_s%0d", s), result, 32'h1);
    end

    step(32'h0, OPB, 6'b111100, 1'b1, 1'b1); check("zero_lez", result, 32'h1);
    step(32'h0, OPB, 6'b111110, 1'b1, 1'b1); check("zero_gtz", result, 32'h0);
    step(32'h0, OPB, 6'b111000, 1'b1, 1'b1); check("zero_gez", result, 32'h1);
    step(32'hFFFF_FFFF, OPB, 6'b111100, 1'b1, 1'b1); check("neg_lez", result, 32'h1);
    step(32'hFFFF_FFFF, OPB, 6'b111000, 1'b1, 1'b1); check("neg_gez", result, 32'h0);
    step(32'hFFFF_FFFF, OPB, 6'b111110, 1'b1, 1'b1); check("neg_gtz", result, 32'h0);
    step(32'hFFFF_FFFF, OPB, 6'b111110, 1'b0, 1'b1); check("uns_gtz", result, 32'h1);
    step(32'hFFFF_FFFF, OPB, 6'b111100, 1'b0, 1'b1); check("uns_lez", result, 32'h0);
    step(32'h8000_0000, 32'h1, 6'b110101, 1'b1, 1'b1); check("lt_ovf", result, 32'h1);

    step(32'h1, 32'h2, 6'b000000, 1'b0, 1'b1); check("lat_add", result, 32'h3);
    step(32'h9, 32'h2, 6'b000001, 1'b0, 1'b0); check("mid_reset", result, 32'h0);
    step(32'h9, 32'h2, 6'b000001, 1'b0, 1'b1); check("post_reset_sub", result, 32'h7);

    step(OPA, OPB, 6'b010000, 1'b0, 1'b1); check("illegal_010000", result, 32'h0);
    step(OPA, OPB, 6'b100010, 1'b1, 1'b1); check("illegal_100010", result, 32'h0);
    step(OPA, OPA, 6'b110111, 1'b1, 1'b1); check("illegal_110111", result, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      ra = pick_operand();
      rb = ($urandom_range(0, 9) == 0) ? ra : pick_operand();
      rf = 6'($urandom_range(0, 63));
      rs = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 24) != 0);
      step(ra, rb, rf, rs, rr);
      exp = rr ? ref_alu(ra, rb, rf, rs) : 32'h0;
      check($sformatf("rand A=%08h B=%08h fun=%06b sign=%0d rst=%0d", ra, rb, rf, rs, rr),
            result, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
MIPS_ALU -- requirements
Module: mips_alu

Interface
REQ-001 The block SHALL use these ports: clk  in  1  rising-edge clock.
REQ-002 The block SHALL use these ports: reset  in  1  reset, active-low.
REQ-003 The block SHALL use these ports: A  in  32  operand A.
REQ-004 The block SHALL use these ports: B  in  32  operand B.
REQ-005 The block SHALL use these ports: ALUFun  in  6  operation select.
REQ-006 The block SHALL use these ports: Sign  in  1  1 = signed compare, 0 = unsigned compare.
REQ-007 The block SHALL use these ports: result  out  32  registered operation result.
REQ-008 The block SHALL have one clock; reset SHALL be synchronous and active-low.

Function
REQ-009 result SHALL be registered: inputs sampled at rising clk edge N; result valid after edge N; latency 1 cycle; new operation every cycle; no handshake.
REQ-010 ALUFun[5:4] SHALL select the class: 00 arith, 01 logic, 10 shift, 11 compare.
REQ-011 Arith, ALUFun[0] = 0: result = A + B mod 2^32. Carry and overflow SHALL be discarded.
REQ-012 Arith, ALUFun[0] = 1: result = A - B mod 2^32, i.e. A + ~B + 1.
REQ-013 Logic, decoded on ALUFun[3:0]: 1000 AND; 1110 OR; 0110 XOR; 0001 NOR; 1010 pass A. Any other code SHALL give result = 0.
REQ-014 Shift: amount = A[4:0] (0..31); operand shifted = B.
- ALUFun[1:0] = 00: SLL (B << A[4:0]).
- 01: SRL, zero fill.
- 11: SRA, fill with B[31].
- 10: result = 0.
- Amount 0 SHALL return B unchanged.
REQ-015 Compare: result[31:1] = 0; result[0] = flag, decoded on ALUFun[3:1]:
- 001 EQ: A == B.
- 000 NEQ: A != B.
- 010 LT: A < B.
- 110 LEZ: A <= 0.
- 100 GEZ: A >= 0.
- 111 GTZ: A > 0.
- Other codes: flag = 0.
REQ-016 When Sign = 1, LT/LEZ/GEZ/GTZ SHALL treat operands as two's complement. When Sign = 0 they SHALL be unsigned, so: LEZ = (A == 0), GEZ = 1, GTZ = (A != 0).
REQ-017 Signed LT SHALL be correct across overflow, e.g. A = 0x80000000 < B = 0x00000001 gives 1.
REQ-018 EQ/NEQ SHALL be independent of Sign.
REQ-019 ALUFun[0] SHALL be ignored in the compare class.
REQ-020 Sign SHALL have no effect on arith, logic or shift results.
REQ-021 The block SHALL have no other internal state; output depends only on the previous-cycle inputs.

Reset
REQ-022 When reset = 0 at a rising clk edge, result SHALL become 0x00000000 at that edge, regardless of other inputs.
REQ-023 Reset asserted mid-stream SHALL discard the operation sampled at that edge.
REQ-024 The first valid result SHALL appear one edge after the first edge with reset = 1.
REQ-025 No asynchronous path from reset to result SHALL exist.

Verification
REQ-026 Arith/logic scenario: A = 0x0000E129, B = 0xFFFF1EDF; step ALUFun through the codes below, one per cycle. Required results:
- ADD -> 0x00000008.
- SUB -> 0x0001C24A.
- AND -> 0x00000009.
- OR -> 0xFFFFFFFF.
- XOR -> 0xFFFFFFF6.
- NOR -> 0x00000000.
- pass A -> 0x0000E129.
REQ-027 Shift scenario: same operands, so amount = 9. Required results:
- SLL -> 0xFE3DBE00.
- SRL -> 0x007FFF8F.
- SRA -> 0xFFFFFF8F.
REQ-028 Compare scenario: same operands. Required results:
- EQ -> 0.
- NEQ -> 1.
- LT with Sign = 1 -> 0; with Sign = 0 -> 1.
- GTZ -> 1; LEZ -> 0; GEZ -> 1 (both Sign values).
REQ-029 Zero/negative scenario: Sign = 1. Required results:
- A = 0 -> LEZ 1, GTZ 0, GEZ 1.
- A = 0xFFFFFFFF -> LEZ 1, GEZ 0, GTZ 0.
- A = 0xFFFFFFFF with Sign = 0 -> GTZ 1, LEZ 0.
REQ-030 Latency/reset scenario:
- Drive ADD with A = 1, B = 2; result = 3 one edge later.
- Assert reset = 0 for one edge with SUB inputs present; result = 0 after that edge.
- Release reset; next edge gives the SUB value.
REQ-031 Illegal-code scenario: ALUFun = 010000, 100010 and 110111 SHALL each give result = 0.
